switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 128 ++++++++++++
 tb/tb_switch_debounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - multi-channel switch debouncer; SWITCH_DEBOUNCE_CHANGE_PULSE_EN enables sw_changed pulses
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_settled,
  output logic [WIDTH-1:0] sw_changed
);

  // Counter only ever reaches DEBOUNCE_CYCLES-1, so $clog2 bits always suffice.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];
  logic [WIDTH-1:0] clean_d;
  logic             settled_d;

  // Two-flop synchronizer on every raw switch bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Per-channel state register: FSM state, run-length counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      sw_clean <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_clean <= clean_d;
    end
  end

  // Next-state logic: a mismatch must persist for DEBOUNCE_CYCLES uninterrupted
  // cycles; any matching cycle drops back to IDLE so the count restarts.
  always_comb begin
    clean_d = sw_clean;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2[i] != sw_clean[i]) begin
            state_d[i] = PENDING;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        PENDING: begin
          if (sync2[i] == sw_clean[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            clean_d[i] = sync2[i];
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic: settled reflects the current (registered) channel states.
  always_comb begin
    settled_d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (state_q[i] == PENDING) settled_d = 1'b0;
    end
  end

  // Settled flag register; reset means nothing is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_settled <= 1'b1;
    else        sw_settled <= settled_d;
  end

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  logic [WIDTH-1:0] changed_d;

  // Change pulse lines up with the cycle sw_clean first shows its new value.
  always_comb begin
    changed_d = clean_d ^ sw_clean;
  end

  // Change pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_changed <= '0;
    else        sw_changed <= changed_d;
  end
`else
  assign sw_changed = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - randomized self-checking bench for switch_debounce
module tb_switch_debounce;

  localparam int W = 4;
  localparam int D = 4;
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  localparam bit CHG_ON = 1'b1;
`else
  localparam bit CHG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [W-1:0] sw_clean;
  logic         sw_settled;
  logic [W-1:0] sw_changed;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sliding window of raw samples, index 0 oldest.
  logic [W-1:0] hist [$];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_changed;
  logic         m_settled;
  logic [W-1:0] m_pend;

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .sw_clean   (sw_clean),
    .sw_settled (sw_settled),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < D + 2; i++) hist.push_back('0);
    m_clean   = '0;
    m_changed = '0;
    m_settled = 1'b1;
    m_pend    = '0;
  endtask

  // A bit flips when the D samples taken 2..D+1 edges ago all disagree with it.
  task automatic model_edge(input logic [W-1:0] s);
    logic [W-1:0] all1;
    logic [W-1:0] all0;
    logic [W-1:0] nc;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back(s);
      void'(hist.pop_front());
      all1 = '1;
      all0 = '1;
      for (int i = 0; i < D; i++) begin
        all1 &= hist[i];
        all0 &= ~hist[i];
      end
      nc        = (m_clean & ~all0) | (~m_clean & all1);
      m_changed = CHG_ON ? (nc ^ m_clean) : '0;
      m_settled = ~|m_pend;
      m_pend    = hist[D-1] ^ nc;
      m_clean   = nc;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clean"},   32'(sw_clean),   32'(m_clean));
    chk({tag, ".changed"}, 32'(sw_changed), 32'(m_changed));
    chk({tag, ".settled"}, 32'(sw_settled), 32'(m_settled));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(sw);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle, released just after an edge.
  task automatic async_reset(input int low_edges);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_now.clean",   32'(sw_clean),   32'(0));
    chk("rst_now.changed", 32'(sw_changed), 32'(0));
    chk("rst_now.settled", 32'(sw_settled), 32'(1));
    repeat (low_edges) tick("rst_low");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    model_reset();
    repeat (3) tick("por");
    rst_n = 1'b1;

    // Idle after reset release
    repeat (20) tick("idle");
    chk("idle.end_clean", 32'(sw_clean), 32'(0));

    // Clean step 0000 -> 0101
    sw = 4'b0101;
    for (int k = 1; k <= 6; k++) begin
      tick("step");
      if (k == 4) chk("step.busy", 32'(sw_settled), 32'(0));
      if (k == 5) chk("step.not_yet", 32'(sw_clean), 32'(0));
      if (k == 6) begin
        chk("step.clean", 32'(sw_clean), 32'(4'b0101));
        chk("step.pulse", 32'(sw_changed), CHG_ON ? 32'(4'b0101) : 32'(0));
      end
    end
    tick("step");
    chk("step.pulse_end", 32'(sw_changed), 32'(0));
    tick("step");
    chk("step.settled", 32'(sw_settled), 32'(1));
    sw = '0;
    repeat (8) tick("step_back");

    // Bounce on bit 0 never accepted
    for (int k = 0; k < 12; k++) begin
      sw = {3'b000, (k % 2 == 0)};
      tick("bounce");
    end
    sw = '0;
    repeat (8) tick("bounce");
    chk("bounce.clean0", 32'(sw_clean[0]), 32'(0));
    chk("bounce.settled", 32'(sw_settled), 32'(1));

    // Bit 3: one cycle short, then exactly long enough
    sw = 4'b1000;
    repeat (3) tick("short");
    sw = '0;
    repeat (8) tick("short");
    chk("short.clean3", 32'(sw_clean[3]), 32'(0));
    sw = 4'b1000;
    repeat (4) tick("exact");
    sw = '0;
    tick("exact");
    tick("exact");
    chk("exact.clean3", 32'(sw_clean[3]), 32'(1));
    repeat (10) tick("exact_back");

    // Reset mid-PENDING with all switches held high
    sw = 4'b1111;
    repeat (5) tick("rpend");
    async_reset(2);
    for (int k = 1; k <= 6; k++) begin
      tick("rpend_rel");
      if (k == 5) chk("rpend.not_yet", 32'(sw_clean), 32'(0));
      if (k == 6) begin
        chk("rpend.clean", 32'(sw_clean), 32'(4'b1111));
        chk("rpend.pulse", 32'(sw_changed), CHG_ON ? 32'(4'b1111) : 32'(0));
      end
    end
    repeat (3) tick("rpend_hold");
    async_reset(1);
    repeat (8) tick("rpend_again");
    chk("rpend.reaccept", 32'(sw_clean), 32'(4'b1111));

    // Randomized holds, bounces and occasional resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset($urandom_range(1, 2));
      end
      if ($urandom_range(0, 2) == 0) sw = sw ^ W'(1 << $urandom_range(0, W - 1));
      else                           sw = W'($urandom);
      repeat ($urandom_range(1, 7)) tick("rand");
    end
    repeat (10) tick("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
